// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch unit: FSM encoding and fixed constants.
package fetch_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    REQ  = 3'd1,
    WAIT = 3'd2,
    DONE = 3'd3,
    ERR  = 3'd4
  } state_t;

  localparam int          WORD_BYTES = 4;
  localparam logic [31:0] RESET_WORD = 32'h0;

endpackage

// File: rtl/Registrador.sv
// Generic 32-bit load-enabled register with asynchronous active-high clear.
module Registrador
  import fetch_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [31:0] in,
  output logic [31:0] out
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out <= RESET_WORD;
    end else if (load) begin
      out <= in;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Single-instruction fetch sequencer: issues one memory read, waits with timeout,
// captures the word into the instruction register and advances the PC.
//
// Handshake: the read strobe is a one-cycle request; mem_ready is honoured only
// while waiting and qualifies mem_rdata in that same cycle. done/err are
// one-cycle completion pulses; start is sampled only while idle.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int WAIT_MAX = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] pc_in,
  output logic [31:0] mem_addr,
  output logic        mem_rd,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  output logic [31:0] ir,
  output logic        pc_write,
  output logic [31:0] pc_next,
  output logic        busy,
  output logic        done,
  output logic        err
);

  localparam logic [7:0] WAIT_LAST = 8'(WAIT_MAX - 1);

  state_t      state;
  logic [31:0] addr_q;
  logic [7:0]  wait_cnt;
  logic        ir_load;

  // The instruction register only ever captures on an accepted memory response.
  assign ir_load = (state == WAIT) && mem_ready;

  Registrador u_ir (
    .clk  (clk),
    .rst  (rst),
    .load (ir_load),
    .in   (mem_rdata),
    .out  (ir)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      addr_q   <= RESET_WORD;
      wait_cnt <= 8'd0;
      mem_addr <= RESET_WORD;
      mem_rd   <= 1'b0;
      pc_write <= 1'b0;
      pc_next  <= RESET_WORD;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      mem_rd   <= 1'b0;
      pc_write <= 1'b0;
      pc_next  <= RESET_WORD;
      done     <= 1'b0;
      err      <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            addr_q <= pc_in;
            busy   <= 1'b1;
            if (pc_in[1:0] != 2'b00) begin
              state    <= ERR;
              err      <= 1'b1;
              mem_addr <= RESET_WORD;
            end else begin
              state    <= REQ;
              mem_rd   <= 1'b1;
              mem_addr <= pc_in;
            end
          end
        end
        REQ: begin
          // mem_addr keeps addr_q through the wait phase
          state    <= WAIT;
          wait_cnt <= 8'd0;
        end
        WAIT: begin
          if (mem_ready) begin
            state    <= DONE;
            pc_write <= 1'b1;
            done     <= 1'b1;
            pc_next  <= addr_q + 32'(WORD_BYTES);
            mem_addr <= RESET_WORD;
          end else if (wait_cnt == WAIT_LAST) begin
            state    <= ERR;
            err      <= 1'b1;
            mem_addr <= RESET_WORD;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        DONE, ERR: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state    <= IDLE;
          busy     <= 1'b0;
          mem_addr <= RESET_WORD;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized and directed bench for fetch_unit with a queue-based scoreboard.
module tb_fetch_unit;

  localparam int W = 100;  // {done, err, pc_write, busy, cycle[31:0], pc_next, ir}

  logic clk, rst;
  int   cyc = 0;

  // main instance (WAIT_MAX = 15)
  logic        start, mem_ready, mem_rd, pc_write, busy, done, err;
  logic [31:0] pc_in, mem_rdata, mem_addr, ir, pc_next;
  // short-timeout instance (WAIT_MAX = 3)
  logic        start3, mem_ready3, mem_rd3, pc_write3, busy3, done3, err3;
  logic [31:0] pc_in3, mem_rdata3, mem_addr3, ir3, pc_next3;

  logic [W-1:0] ev_q[$];
  logic [W-1:0] ev3_q[$];
  logic [63:0]  rd_q[$];
  logic [31:0]  model_ir[2];

  int tests = 0, fails = 0;
  int busy_cnt = 0, pw_cnt = 0, pw3_cnt = 0;
  logic        prev_rd = 1'b0;
  logic [31:0] prev_addr = 32'h0;

  fetch_unit #(.WAIT_MAX(15)) dut (
    .clk(clk), .rst(rst), .start(start), .pc_in(pc_in),
    .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .ir(ir), .pc_write(pc_write), .pc_next(pc_next),
    .busy(busy), .done(done), .err(err)
  );

  fetch_unit #(.WAIT_MAX(3)) dut3 (
    .clk(clk), .rst(rst), .start(start3), .pc_in(pc_in3),
    .mem_addr(mem_addr3), .mem_rd(mem_rd3), .mem_rdata(mem_rdata3), .mem_ready(mem_ready3),
    .ir(ir3), .pc_write(pc_write3), .pc_next(pc_next3),
    .busy(busy3), .done(done3), .err(err3)
  );

  // clock / cycle counter
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #300000;
    $display("FAIL watchdog: got no end of stimulus, required finish within time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h required %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_reset(input string name);
    check({name, "_main"}, {mem_addr, mem_rd, ir, pc_write, pc_next, busy, done, err}, '0);
    check({name, "_wm3"}, {mem_addr3, mem_rd3, ir3, pc_write3, pc_next3, busy3, done3, err3}, '0);
  endtask

  // monitors / scoreboard
  always @(negedge clk) begin
    if (busy) busy_cnt++;
    if (pc_write) pw_cnt++;
    if (pc_write3) pw3_cnt++;
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (prev_rd) check("wait_addr_hold", {mem_rd, mem_addr}, {1'b0, prev_addr});
      if (mem_rd) begin
        if (rd_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_mem_rd: got strobe addr %h, required none (cycle %0d)", mem_addr, cyc);
        end else begin
          check("mem_rd", {32'(cyc), mem_addr}, rd_q.pop_front());
        end
      end
      prev_rd   = mem_rd;
      prev_addr = mem_addr;
      if (done || err) begin
        if (ev_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_event: got done=%b err=%b, required none (cycle %0d)", done, err, cyc);
        end else begin
          check("event", {done, err, pc_write, busy, 32'(cyc), pc_next, ir}, ev_q.pop_front());
        end
      end
      if (!pc_write) check("pc_next_zero", pc_next, 0);
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (done3 || err3) begin
        if (ev3_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_event_wm3: got done=%b err=%b, required none (cycle %0d)", done3, err3, cyc);
        end else begin
          check("event_wm3", {done3, err3, pc_write3, busy3, 32'(cyc), pc_next3, ir3}, ev3_q.pop_front());
        end
      end
      if (!pc_write3) check("pc_next_zero_wm3", pc_next3, 0);
    end
  end

  // driver tasks
  task automatic drive(input bit sel, input logic st, input logic [31:0] pc,
                       input logic rdy, input logic [31:0] d);
    if (sel) begin
      start3 = st; pc_in3 = pc; mem_ready3 = rdy; mem_rdata3 = d;
    end else begin
      start = st; pc_in = pc; mem_ready = rdy; mem_rdata = d;
    end
  endtask

  task automatic step_busy(input bit sel, input bit hold, input logic rdy, input logic [31:0] d);
    drive(sel, hold ? 1'b1 : 1'($urandom_range(0, 1)), $urandom, rdy, d);
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      drive(1'b0, 1'b0, $urandom, 1'($urandom_range(0, 1)), $urandom);
      drive(1'b1, 1'b0, $urandom, 1'($urandom_range(0, 1)), $urandom);
      @(posedge clk); #1;
    end
  endtask

  // One fetch; lat = WAIT cycles without mem_ready before the response.
  // Called in an idle cycle; returns in the following idle cycle with start = hold.
  task automatic fetch(input bit sel, input logic [31:0] pc, input logic [31:0] data,
                       input int lat, input bit hold);
    int wm, k, n;
    logic [W-1:0] e;
    wm = sel ? 3 : 15;
    k  = cyc + 1;
    // reference outcome from the fetch rules
    if (pc[1:0] != 2'b00)
      e = {4'b0101, 32'(k), 32'h0, model_ir[sel]};
    else if (lat >= wm)
      e = {4'b0101, 32'(k + 1 + wm), 32'h0, model_ir[sel]};
    else begin
      e = {4'b1011, 32'(k + 2 + lat), pc + 32'd4, data};
      model_ir[sel] = data;
    end
    if (sel) ev3_q.push_back(e);
    else     ev_q.push_back(e);
    if (!sel && pc[1:0] == 2'b00) rd_q.push_back({32'(k), pc});

    drive(sel, 1'b1, pc, 1'($urandom_range(0, 1)), $urandom);
    @(posedge clk); #1;
    if (pc[1:0] != 2'b00) begin
      step_busy(sel, hold, 1'($urandom_range(0, 1)), $urandom);
    end else begin
      step_busy(sel, hold, 1'($urandom_range(0, 1)), $urandom);
      n = (lat < wm) ? lat : wm;
      for (int i = 0; i < n; i++) step_busy(sel, hold, 1'b0, $urandom);
      if (lat < wm) begin
        step_busy(sel, hold, 1'b1, data);
        step_busy(sel, hold, 1'($urandom_range(0, 1)), $urandom);
      end else begin
        step_busy(sel, hold, 1'($urandom_range(0, 1)), $urandom);
      end
    end
    drive(sel, hold, pc, 1'b0, 32'h0);
  endtask

  // stimulus
  initial begin
    int b0, p0, k;
    logic [31:0] pc, d;
    int lat;
    bit hold;

    rst = 1'b1;
    drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    drive(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    model_ir[0] = 32'h0;
    model_ir[1] = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    check_reset("reset_state");
    rst = 1'b0;
    idle(2);

    // basic fetch
    fetch(1'b0, 32'h0000_0010, 32'h8C22_0004, 0, 1'b0);
    check("basic_ir", ir, 32'h8C22_0004);
    idle(1);

    // slow memory
    b0 = busy_cnt; p0 = pw_cnt;
    fetch(1'b0, 32'h0000_0200, 32'hA5A5_0001, 5, 1'b0);
    check("slow_busy_cycles", busy_cnt - b0, 8);
    check("slow_pc_write_count", pw_cnt - p0, 1);
    idle(1);

    // timeout on the short-timeout instance, ir keeps the prior word
    fetch(1'b1, 32'h0000_0100, 32'h1111_2222, 1, 1'b0);
    p0 = pw3_cnt;
    fetch(1'b1, 32'h0000_0104, 32'h3333_4444, 10, 1'b0);
    check("timeout_pc_write_count", pw3_cnt - p0, 0);
    check("timeout_ir_kept", ir3, 32'h1111_2222);
    idle(1);

    // misaligned
    p0 = pw_cnt;
    fetch(1'b0, 32'h0000_0006, 32'hDEAD_BEEF, 0, 1'b0);
    check("misalign_pc_write_count", pw_cnt - p0, 0);
    idle(1);

    // wrap with start held, then back-to-back fetch
    fetch(1'b0, 32'hFFFF_FFFC, 32'h0BAD_F00D, 2, 1'b1);
    fetch(1'b0, 32'h0000_0020, 32'h2020_2020, 0, 1'b0);
    idle(1);

    // reset during the second WAIT cycle
    k = cyc + 1;
    rd_q.push_back({32'(k), 32'h0000_0040});
    drive(1'b0, 1'b1, 32'h0000_0040, 1'b0, 32'h0);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, $urandom, 1'b0, 32'h0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check_reset("reset_mid_wait");
    model_ir[0] = 32'h0;
    model_ir[1] = 32'h0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    fetch(1'b0, 32'h0000_0044, 32'h1234_5678, 0, 1'b0);
    check("post_reset_ir", ir, 32'h1234_5678);
    idle(1);

    // randomized traffic
    for (int i = 0; i < 40; i++) begin
      pc   = {$urandom} & 32'hFFFF_FFFC;
      if ($urandom_range(0, 5) == 0) pc[1:0] = 2'($urandom_range(1, 3));
      d    = $urandom;
      lat  = $urandom_range(0, 17);
      hold = (i < 39) && ($urandom_range(0, 3) == 0);
      fetch(1'b0, pc, d, lat, hold);
      if (!hold) idle($urandom_range(0, 2));
    end

    idle(4);
    check("ev_q_drained", ev_q.size(), 0);
    check("ev3_q_drained", ev3_q.size(), 0);
    check("rd_q_drained", rd_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
